// File: rtl/imdct_norm_pkg.sv
// Shared constants and types for IMDCT block normalisation.
// Holds sample width, shift width, default block size and FSM states.
package imdct_norm_pkg;

  localparam int DW    = 32;
  localparam int SHW   = 5;
  localparam int N_DEF = 36;

  typedef enum logic {
    FILL,
    DRAIN
  } state_e;

endpackage

// File: rtl/imdct_cls32.sv
// Count leading sign bits minus one of a 32-bit signed word (0..31).
// Ports: din[31:0] sample in, cls[4:0] redundant sign bit count out.
module imdct_cls32 (
  input  logic [31:0] din,
  output logic [4:0]  cls
);

  logic [30:0] diff;

  // A set bit marks the first position that differs from the sign.
  assign diff = din[30:0] ^ {31{din[31]}};

  always_comb begin
    cls = 5'd31;
    for (int i = 0; i < 31; i++) begin
      if (diff[i]) cls = 5'(30 - i);
    end
  end

endmodule

// File: rtl/imdct_blk_norm.sv
// Block-floating-point normaliser: buffers N samples, finds min headroom,
// replays the block with a common shift. Ports: in_* / out_* valid-ready
// streams, out_shift (barrel shifter ctrl), blk_exp (last block exponent).
module imdct_blk_norm
  import imdct_norm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [SHW-1:0] out_shift,
  output logic           out_last,
  output logic [SHW-1:0] blk_exp
);

  state_e         state;
  state_e         state_nx;
  logic [AW-1:0]  wr_cnt;
  logic [AW-1:0]  rd_cnt;
  logic [SHW-1:0] run_min;
  logic [SHW-1:0] min_nx;
  logic [SHW-1:0] cls;
  logic [SHW-1:0] shift_reg;
  logic [DW-1:0]  mem [N];
  logic           wr_en;
  logic           rd_en;
  logic           wr_last;
  logic           rd_last;

  imdct_cls32 u_cls (
    .din (in_data),
    .cls (cls)
  );

  assign wr_en   = in_valid && (state == FILL);
  assign rd_en   = out_ready && (state == DRAIN);
  assign wr_last = (wr_cnt == AW'(N - 1));
  assign rd_last = (rd_cnt == AW'(N - 1));
  assign min_nx  = (cls < run_min) ? cls : run_min;

  assign out_data  = mem[rd_cnt];
  assign out_shift = shift_reg;
  assign out_last  = (state == DRAIN) && rd_last;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (wr_en && wr_last) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (rd_en && rd_last) state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      run_min   <= 5'd31;
      shift_reg <= '0;
      blk_exp   <= '0;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          wr_cnt    <= '0;
          run_min   <= 5'd31;
          shift_reg <= min_nx;
          blk_exp   <= min_nx;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
          run_min <= min_nx;
        end
      end
      if (rd_en) begin
        if (rd_last) rd_cnt <= '0;
        else         rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Buffer contents survive reset; only the counters restart.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= in_data;
  end

endmodule

// File: tb/tb_imdct_blk_norm.sv
// Randomised self-checking bench for imdct_blk_norm.
// Compares every cycle against a block-level headroom reference model.
module tb_imdct_blk_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_shift;
  logic        out_last;
  logic [4:0]  blk_exp;

  int vectors = 0;
  int errors  = 0;
  int prev_exp = 0;
  logic [31:0] blk [36];

  always #5 clk = ~clk;

  imdct_blk_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_last  (out_last),
    .blk_exp   (blk_exp)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Headroom = largest left shift that round-trips without overflow.
  function automatic int ref_cls(input logic [31:0] x);
    logic signed [31:0] v;
    logic signed [31:0] t;
    v = x;
    for (int s = 31; s >= 0; s--) begin
      t = (v <<< s) >>> s;
      if (t == v) return s;
    end
    return 0;
  endfunction

  function automatic int ref_shift();
    int m = 31;
    foreach (blk[i]) if (ref_cls(blk[i]) < m) m = ref_cls(blk[i]);
    return m;
  endfunction

  task automatic run_block(input int rdy_pct, input int abort_at);
    int exp_sh;
    int k;
    int cyc;
    exp_sh = ref_shift();
    for (int i = 0; i < 36; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      out_ready = ($urandom_range(99) < 50);
      check("fill_in_ready", in_ready, 1);
      check("fill_out_valid", out_valid, 0);
      check("fill_blk_exp", blk_exp, prev_exp);
      @(posedge clk); #1;
    end
    k = 0;
    cyc = 0;
    while (k < 36 && cyc < 1000) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_blk_exp", blk_exp, 0);
        check("rst_out_shift", out_shift, 0);
        prev_exp = 0;
        return;
      end
      in_valid  = 1'b1;
      in_data   = $urandom;
      out_ready = ($urandom_range(99) < rdy_pct);
      check("drain_in_ready", in_ready, 0);
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, blk[k]);
      check("drain_out_shift", out_shift, exp_sh);
      check("drain_out_last", out_last, (k == 35));
      check("drain_blk_exp", blk_exp, exp_sh);
      @(posedge clk); #1;
      if (out_ready) k++;
      cyc++;
    end
    if (cyc >= 1000) check("drain_timeout", 0, 1);
    if (rdy_pct == 100) check("drain_cycles", cyc, 36);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    prev_exp = exp_sh;
  endtask

  task automatic fill_const(input logic [31:0] v);
    foreach (blk[i]) blk[i] = v;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_shift", out_shift, 0);
    check("reset_blk_exp", blk_exp, 0);

    fill_const(32'h0000_0100);
    check("model_0100", ref_shift(), 22);
    run_block(100, -1);

    fill_const(32'h0000_0010);
    blk[17] = 32'h8000_0000;
    run_block(100, -1);
    blk[17] = 32'hFFFF_FF00;
    check("model_ff00", ref_shift(), 23);
    run_block(100, -1);

    fill_const(32'h0000_0000);
    run_block(100, -1);
    fill_const(32'hFFFF_FFFF);
    run_block(100, -1);
    fill_const(32'h0000_0100);
    run_block(100, -1);

    for (int b = 0; b < 4; b++) begin
      foreach (blk[i]) blk[i] = $signed($urandom) >>> $urandom_range(31);
      if (b == 1) blk[$urandom_range(35)] = 32'h7FFF_FFFF;
      run_block(50, -1);
    end

    fill_const(32'h0000_0100);
    blk[3] = 32'h0001_0000;
    run_block(100, 10);
    fill_const(32'h0000_0100);
    run_block(100, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imdct_blk_norm.md
Name: imdct_blk_norm

Overview:
- Block-floating-point normaliser directly upstream of the IMDCT 32-bit left barrel shifter.
- Buffers one block of N signed 32-bit IMDCT samples and finds the smallest headroom across the block, i.e. the number of redundant sign bits.
- Replays the block with that common shift amount, which drives the barrel shifter's 5-bit control input.
- Also reports the shift as the block exponent for later de-normalisation.

Parameters:
- DW, 32, sample width in bits; fixed at 32 to match the shifter.
- N, 36, samples per block (long-block IMDCT output).
- AW, 6, buffer address/counter width; must satisfy 2^AW >= N.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  signed two's-complement sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_data  out  32  buffered sample, unmodified.
- out_shift  out  5  common left-shift amount for the block, feeding the barrel shifter ctrl.
- out_last  out  1  high on the N-th output sample of the block.
- blk_exp  out  5  shift of the most recently completed block; held until the next block's drain starts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=FILL, wr/rd count=0, run_min=31, in_ready=1, out_valid=0, out_last=0, out_shift=0, blk_exp=0. out_data is don't-care while out_valid=0; buffer RAM is not cleared.
- Headroom per sample (cls): count of leading bits equal to bit 31, minus 1; range 0..31.
  - 0x0000_0000 and 0xFFFF_FFFF give 31.
  - 0x4000_0000 and 0x8000_0000 give 0.
- FSM: two states, FILL and DRAIN.
- FILL:
  - in_ready=1 and out_valid=0.
  - On each in_valid&&in_ready: write in_data to buf[wr_cnt], set run_min = min(run_min, cls(in_data)), increment wr_cnt.
  - On the acceptance of the N-th sample, the min includes that sample. Go to DRAIN, latch shift_reg = final min, and load blk_exp with the same value.
  - Clear wr_cnt=0 and run_min=31 on the same edge.
- DRAIN:
  - in_ready=0; in_valid is ignored and no samples are written.
  - out_valid=1 starting the cycle after the N-th input is accepted, so latency from last input to first output is 1 cycle.
  - out_data=buf[rd_cnt] and out_shift=shift_reg, constant for the whole block.
  - out_last=1 when rd_cnt==N-1.
  - On out_valid&&out_ready: increment rd_cnt.
  - On the transfer with out_last: rd_cnt=0, go to FILL, and in_ready=1 in the next cycle.
- Handshake rules:
  - out_data, out_shift and out_last stay stable while out_valid&&!out_ready.
  - Throughput is 1 sample/cycle in each phase.
  - Phases do not overlap (single buffer), so sustained rate is N in, then N out.
- Buffer read: asynchronous (distributed RAM), or registered with read-ahead. Either way, out_data must be valid in the same cycle out_valid is high, with no bubbles between outputs when out_ready=1.
- Boundary conditions:
  - All-zero or all -1 block gives shift 31.
  - A single full-scale sample anywhere in the block forces shift 0.
  - run_min saturates naturally at 0; no underflow.
- Reset mid-operation: in either state, rst returns the block to reset values on the next edge.
  - A partially filled block is discarded.
  - A partially drained block is abandoned: out_valid drops in the cycle after rst is sampled.

Decomposition:
- Shared package imdct_norm_pkg holds: DW=32, SHW=5, default N=36, and the state enum {FILL, DRAIN}.
- One combinational sub-module, imdct_cls32: input din[31:0], output cls[4:0] (count leading sign bits minus 1). It is reusable by other IMDCT normalisation points.
- FSM, counters and buffer live in the top module.

Test Plan:
- 36 samples of 0x0000_0100 -> out_shift=22 and blk_exp=22 on all outputs; out_data=0x0000_0100 ×36; out_last only on the 36th output; first out_valid 1 cycle after the last input.
- 35 samples of 0x0000_0010 plus one 0x8000_0000 at index 17 -> out_shift=0. Repeat with 0xFFFF_FF00 as the only large sample -> out_shift=23.
- All-0x0000_0000 block and all-0xFFFF_FFFF block -> out_shift=31 for each; the run_min reset between blocks is checked by a following block of 0x0000_0100 giving 22.
- Random out_ready (50%) during DRAIN plus in_valid held high -> in_ready=0 throughout DRAIN; outputs stable under stall; no sample lost, duplicated or written.
- Back-to-back blocks with in_valid and out_ready always 1 -> exactly N input cycles then N output cycles, no idle cycle beyond the 1-cycle latency; blk_exp updates per block.
- rst asserted after 10 outputs of a drain -> out_valid=0 and in_ready=1 in the next cycle; the next full block of 0x0000_0100 yields shift 22 and 36 correct outputs.
